// File: rtl/board_pkg.sv
// Shared board definitions for the loader, renderer and movement logic.
// Holds the maze dimensions, the tile code set and the loader FSM state type.
package board_pkg;

    localparam int unsigned BOARD_COLS = 28;
    localparam int unsigned BOARD_ROWS = 31;

    typedef enum logic [3:0] {
        TILE_EMPTY = 4'd0,
        TILE_WALL  = 4'd1,
        TILE_DOT   = 4'd2,
        TILE_POWER = 4'd3,
        TILE_DOOR  = 4'd4
    } tile_e;

    typedef enum logic [1:0] {
        LD_IDLE,
        LD_FETCH,
        LD_FLUSH,
        LD_DONE
    } loader_state_e;

endpackage

// File: rtl/board_loader.sv
// board_loader: copies the initial maze image from the board ROM into the live
// board RAM, one tile per cycle, counting edible tiles (dots + power pellets).
// Completion is reported over a four-phase reload/done handshake.
//
// Ports:
//   i_clk, i_rst_n        clock, asynchronous active-low reset
//   i_board_reload        reload request level from the game controller
//   o_board_reload_done   load-complete level back to the game controller
//   o_busy                high while this block owns the RAM write port
//   o_rom_addr/i_rom_data synchronous ROM read port (1-cycle latency)
//   o_ram_we/addr/wdata   board RAM write port
//   o_dot_count           edible tiles written in the current or last load
module board_loader #(
    parameter int unsigned BOARD_COLS = board_pkg::BOARD_COLS,
    parameter int unsigned BOARD_ROWS = board_pkg::BOARD_ROWS,
    parameter int unsigned TILE_W     = 4,
    parameter int unsigned ADDR_W     = 10,
    parameter int unsigned CNT_W      = 10
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_board_reload,
    output logic              o_board_reload_done,
    output logic              o_busy,
    output logic [ADDR_W-1:0] o_rom_addr,
    input  logic [TILE_W-1:0] i_rom_data,
    output logic              o_ram_we,
    output logic [ADDR_W-1:0] o_ram_addr,
    output logic [TILE_W-1:0] o_ram_wdata,
    output logic [CNT_W-1:0]  o_dot_count
);
    import board_pkg::*;

    localparam int unsigned      NumTiles = BOARD_COLS * BOARD_ROWS;
    localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(NumTiles - 1);
    localparam logic [CNT_W-1:0]  CntMax   = {CNT_W{1'b1}};

    loader_state_e     r_state;
    logic [ADDR_W-1:0] r_rd_addr;
    logic [ADDR_W-1:0] r_wr_addr;
    logic              r_wr_valid;
    logic              r_done;
    logic              r_busy;
    logic [CNT_W-1:0]  r_dot_count;

    logic              w_write;
    logic              w_edible;

    // Dropping the request kills the pending write in the very cycle it is seen.
    assign w_write  = r_wr_valid & i_board_reload;
    assign w_edible = (i_rom_data == TILE_W'(TILE_DOT)) ||
                      (i_rom_data == TILE_W'(TILE_POWER));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= LD_IDLE;
            r_rd_addr   <= '0;
            r_wr_addr   <= '0;
            r_wr_valid  <= 1'b0;
            r_done      <= 1'b0;
            r_busy      <= 1'b0;
            r_dot_count <= '0;
        end else begin
            if (w_write && w_edible && (r_dot_count != CntMax)) begin
                r_dot_count <= r_dot_count + CNT_W'(1);
            end

            case (r_state)
                LD_IDLE: begin
                    r_wr_valid <= 1'b0;
                    if (i_board_reload) begin
                        r_state     <= LD_FETCH;
                        r_rd_addr   <= '0;
                        r_dot_count <= '0;
                        r_busy      <= 1'b1;
                    end
                end
                LD_FETCH: begin
                    if (!i_board_reload) begin
                        r_state    <= LD_IDLE;
                        r_wr_valid <= 1'b0;
                        r_busy     <= 1'b0;
                    end else begin
                        // Pipeline stage aligns the write address with ROM read latency.
                        r_wr_valid <= 1'b1;
                        r_wr_addr  <= r_rd_addr;
                        if (r_rd_addr == LastAddr) begin
                            r_state <= LD_FLUSH;
                        end else begin
                            r_rd_addr <= r_rd_addr + ADDR_W'(1);
                        end
                    end
                end
                LD_FLUSH: begin
                    r_wr_valid <= 1'b0;
                    r_busy     <= 1'b0;
                    if (!i_board_reload) begin
                        r_state <= LD_IDLE;
                    end else begin
                        r_state <= LD_DONE;
                        r_done  <= 1'b1;
                    end
                end
                LD_DONE: begin
                    if (!i_board_reload) begin
                        r_state <= LD_IDLE;
                        r_done  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= LD_IDLE;
                end
            endcase
        end
    end

    assign o_board_reload_done = r_done;
    assign o_busy              = r_busy;
    assign o_rom_addr          = r_rd_addr;
    assign o_ram_we            = w_write;
    assign o_ram_addr          = r_wr_addr;
    assign o_ram_wdata         = i_rom_data;
    assign o_dot_count         = r_dot_count;

endmodule
